carryskip_operand_sequencer: RTL and testbench
==============================================

// Module: carryskip_operand_sequencer
// PURPOSE
// Upstream front-end for the 8-bit carry-skip adder. Collects operand A then operand B as two bytes
// over one valid/ready byte stream and drives them as stable registered operands to the adder.
// Waits out the adder's registered latency, then returns the 8-bit sum on a valid/ready result port.
// Counts completed transactions for debug.
// PARAMETERS
// ADDER_LAT  1  adder input-to-registered-sum latency in clk cycles (>=1)
// COUNT_W    8  width of completed-transaction counter
// PORTS
// clk        in   1        single clock, rising edge
// rst        in   1        synchronous, active-high reset
// in_data    in   8        operand byte; first byte of a pair = A, second = B
// in_valid   in   1        in_data valid
// in_ready   out  1        sequencer accepts in_data this cycle
// add_a      out  8        operand A to adder (registered)
// add_b      out  8        operand B to adder (registered)
// add_sum    in   8        registered sum returned by adder
// out_sum    out  8        result (A+B) mod 256
// out_valid  out  1        out_sum valid
// out_ready  in   1        consumer accepts out_sum
// busy       out  1        high in any state except GET_A
// txn_count  out  COUNT_W  completed result handshakes; wraps
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=GET_A; add_a=add_b=out_sum=0; out_valid=0; txn_count=0;
//   lat_cnt=0. Any in-flight pair is discarded; the mid-operation result is never presented.
// - Byte handshake: in_valid & in_ready at posedge. Result handshake: out_valid & out_ready at posedge.
// - FSM:
//   GET_A: in_ready=1. On byte handshake: add_a<=in_data; goto GET_B.
//   GET_B: in_ready=1. On byte handshake: add_b<=in_data; lat_cnt<=0; goto ISSUE.
//   ISSUE: in_ready=0; add_a/add_b held stable.
//     If lat_cnt==ADDER_LAT: out_sum<=add_sum; out_valid<=1; goto HOLD.
//     Else: lat_cnt<=lat_cnt+1.
//     ISSUE therefore lasts ADDER_LAT+1 cycles.
//   HOLD: in_ready=0; out_sum/out_valid stable until the result handshake.
//     On handshake: out_valid<=0; txn_count<=txn_count+1 (mod 2^COUNT_W); goto GET_A.
// - Latency, default parameters: B-byte handshake edge to out_valid high = 3 rising edges.
//   Best-case throughput: one pair per 5 cycles.
// - in_valid while in_ready=0: ignored, never buffered. Producer must hold in_data/in_valid.
// - out_ready while out_valid=0: ignored.
// - add_a/add_b keep their last values in GET_A/GET_B. Adder output is sampled only in ISSUE.
// - No carry-out: the sum wraps mod 256 (0xFF+0x01 -> 0x00).
// - lat_cnt width = $clog2(ADDER_LAT+1).
// - No X on any output after reset.
// TESTING
// Bench instantiates the real adder: add_a->a, add_b->b, add_sum<-sum, adder rst_n = ~rst.
// T1: bytes 0x0F,0x01 (in_valid continuous), out_ready=1 -> out_sum=0x10 3 edges after B handshake;
//     txn_count=1; busy low after the handshake.
// T2: 0xFF,0x01 -> out_sum=0x00. 0x55,0xAA -> out_sum=0xFF.
//     0xAA,0x55 (full-propagate lower nibble, skip path) -> 0xFF.
// T3: 0x12,0x34 with out_ready=0 for 10 cycles -> out_valid=1 and out_sum=0x46 held stable,
//     in_ready=0 throughout; after out_ready pulse -> txn_count increments once, state GET_A.
// T4: send A=0x80, assert rst for 1 cycle during ISSUE -> all outputs reset values, out_valid never 1;
//     then 0x01,0x02 -> 0x03 (stale A not used).
// T5: COUNT_W=2, 5 back-to-back pairs with out_ready=1 -> txn_count sequence 1,2,3,0,1.
// T6: in_valid held high through ISSUE/HOLD with a changing in_data -> extra bytes not consumed;
//     the next pair starts only after the result handshake.

Source files
------------

// File: rtl/carryskip_operand_sequencer_if.sv
// rtl/carryskip_operand_sequencer_if.sv - byte-in / sum-out valid/ready handshake bundle
interface carryskip_operand_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_sum;
  logic       out_valid;
  logic       out_ready;

  // Producer/consumer side: drives bytes in, accepts sums out
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sum, out_valid
  );

  // Sequencer side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sum, out_valid
  );
endinterface

// File: rtl/carryskip_operand_sequencer.sv
// rtl/carryskip_operand_sequencer.sv - collects A/B bytes, drives the adder, returns the sum
module carryskip_operand_sequencer #(
  parameter int ADDER_LAT = 1,
  parameter int COUNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  carryskip_operand_sequencer_if.slave bus,
  output logic [7:0]                   add_a,
  output logic [7:0]                   add_b,
  input  logic [7:0]                   add_sum,
  output logic                         busy,
  output logic [COUNT_W-1:0]           txn_count
);

  localparam int                LAT_W    = $clog2(ADDER_LAT + 1);
  // Final ISSUE cycle: the adder's registered sum is valid for the held operands
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ADDER_LAT);

  localparam logic [1:0] ST_GET_A = 2'd0;
  localparam logic [1:0] ST_GET_B = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [7:0]         add_a_q, add_a_d;
  logic [7:0]         add_b_q, add_b_d;
  logic [7:0]         out_sum_q, out_sum_d;
  logic               out_valid_q, out_valid_d;
  logic [COUNT_W-1:0] txn_count_q, txn_count_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;

  logic in_ready;
  logic byte_hs;
  logic res_hs;

  // Byte acceptance depends only on state, so in_ready never combinationally follows in_valid
  always_comb begin
    in_ready = (state_q == ST_GET_A) || (state_q == ST_GET_B);
    byte_hs  = bus.in_valid && in_ready;
    res_hs   = out_valid_q && bus.out_ready;
  end

  // Next-state and datapath update for the A -> B -> ISSUE -> HOLD sequence
  always_comb begin
    state_d     = state_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    txn_count_d = txn_count_q;
    lat_cnt_d   = lat_cnt_q;
    case (state_q)
      ST_GET_A: begin
        if (byte_hs) begin
          add_a_d = bus.in_data;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (byte_hs) begin
          add_b_d   = bus.in_data;
          lat_cnt_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Operands stay frozen while the adder settles; sample its output once
        if (lat_cnt_q == LAT_LAST) begin
          out_sum_d   = add_sum;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_HOLD: begin
        if (res_hs) begin
          out_valid_d = 1'b0;
          txn_count_d = txn_count_q + COUNT_W'(1);
          state_d     = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
  end

  // State registers; reset drops any in-flight pair and its pending result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GET_A;
      add_a_q     <= '0;
      add_b_q     <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      txn_count_q <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      txn_count_q <= txn_count_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  // Output wiring
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_sum   = out_sum_q;
    bus.out_valid = out_valid_q;
    add_a         = add_a_q;
    add_b         = add_b_q;
    busy          = (state_q != ST_GET_A);
    txn_count     = txn_count_q;
  end

endmodule

// File: tb/tb_carryskip_operand_sequencer.sv
// tb/tb_carryskip_operand_sequencer.sv - self-checking bench for carryskip_operand_sequencer
module tb_carryskip_operand_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carryskip_operand_sequencer_if bus_m();
  carryskip_operand_sequencer_if bus_n();

  logic [7:0] a_m, b_m, s_m, a_n, b_n, s_n;
  logic       busy_m, busy_n;
  logic [7:0] cnt_m;
  logic [1:0] cnt_n;
  logic       rst_n;

  assign rst_n = ~rst;

  // Second instance (COUNT_W=2) sees identical stimulus for counter-wrap checking
  assign bus_n.in_data   = bus_m.in_data;
  assign bus_n.in_valid  = bus_m.in_valid;
  assign bus_n.out_ready = bus_m.out_ready;

  carryskip_operand_sequencer #(.ADDER_LAT(1), .COUNT_W(8)) dut_m (
    .clk(clk), .rst(rst), .bus(bus_m),
    .add_a(a_m), .add_b(b_m), .add_sum(s_m),
    .busy(busy_m), .txn_count(cnt_m)
  );

  carryskip_operand_sequencer #(.ADDER_LAT(1), .COUNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n),
    .add_a(a_n), .add_b(b_n), .add_sum(s_n),
    .busy(busy_n), .txn_count(cnt_n)
  );

  // Registered 8-bit adders (one cycle latency), active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_m <= 8'h00;
      s_n <= 8'h00;
    end else begin
      s_m <= a_m + b_m;
      s_n <= a_n + b_n;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  task automatic check_reset_state();
    check("reset_operands", {8'h00, a_m, b_m, bus_m.out_sum}, 32'h0);
    check("reset_flags", {29'h0, bus_m.out_valid, busy_m, bus_m.in_ready}, 32'h1);
    check("reset_count", {22'h0, cnt_m, cnt_n}, 32'h0);
  endtask

  // Called at a negedge; holds rst for n edges, then releases it
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    exp_count = 0;
  endtask

  // Present a byte and wait (bounded) for its handshake; ends at the following negedge
  task automatic send_byte(input logic [7:0] b, input bit keep);
    bus_m.in_data  = b;
    bus_m.in_valid = 1'b1;
    for (int i = 0; i < 32 && !bus_m.in_ready; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    if (!bus_m.in_ready) check("in_ready_timeout", bus_m.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) bus_m.in_valid = 1'b0;
  endtask

  // Starts at the negedge after the B handshake; checks latency, hold, result handshake
  task automatic finish_pair(input logic [7:0] a, input logic [7:0] b, input logic [7:0] expv,
                             input int hold, input bit churn, input logic [7:0] next_a);
    int edges = 1;
    bit quiet = 1'b1;
    while (!bus_m.out_valid && edges < 20) begin
      if (bus_m.in_ready || a_m !== a || b_m !== b) quiet = 1'b0;
      if (churn) bus_m.in_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check("result_latency", edges, 3);
    check("result_sum", bus_m.out_sum, expv);
    for (int i = 0; i < hold; i++) begin
      if (churn) bus_m.in_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (!bus_m.out_valid || bus_m.out_sum !== expv || bus_m.in_ready ||
          a_m !== a || b_m !== b) quiet = 1'b0;
    end
    check("issue_hold_quiet", quiet, 1);
    if (churn) bus_m.in_data = next_a;
    bus_m.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_m.out_ready = 1'b0;
    exp_count++;
    check("out_valid_drop", bus_m.out_valid, 0);
    check("txn_count", cnt_m, exp_count % 256);
    check("txn_count_w2", cnt_n, exp_count % 4);
    check("idle_after_result", {busy_m, bus_m.in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    int         hold;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] bb[10];
  int exp_seq[5];

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 8'h10, 0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 0};
    vecs[2] = '{8'h55, 8'hAA, 8'hFF, 1};
    vecs[3] = '{8'hAA, 8'h55, 8'hFF, 2};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 10};
    exp_seq = '{1, 2, 3, 0, 1};

    rst = 1'b1;
    bus_m.in_data   = 8'h00;
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Directed vectors: A then B with in_valid continuous
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].a, 1'b1);
      send_byte(vecs[i].b, 1'b0);
      finish_pair(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].hold, 1'b0, 8'h00);
    end

    // Reset during ISSUE discards the pair; result never appears
    begin
      bit seen = 1'b0;
      send_byte(8'h80, 1'b1);
      send_byte(8'h7F, 1'b0);
      check("in_issue", {busy_m, bus_m.in_ready}, 2'b10);
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus_m.out_valid) seen = 1'b1;
      end
      check("no_result_after_reset", seen, 0);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b0);
      finish_pair(8'h01, 8'h02, 8'h03, 0, 1'b0, 8'h00);
    end

    // Reset with only A captured: stale A must not leak into the next pair
    send_byte(8'h80, 1'b0);
    do_reset(1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b0);
    finish_pair(8'h01, 8'h02, 8'h03, 0, 1'b0, 8'h00);

    // Back-to-back pairs with out_ready held high: wrap of 2-bit counter, 5-cycle spacing
    begin
      int idx = 0;
      int nres = 0;
      int last_cyc = -1;
      bit hs_in, hs_out;
      logic [7:0] got;
      @(negedge clk);
      do_reset(1);
      for (int i = 0; i < 10; i++) bb[i] = 8'($urandom);
      bus_m.out_ready = 1'b1;
      for (int cyc = 0; cyc < 80 && nres < 5; cyc++) begin
        bus_m.in_valid = (idx < 10);
        bus_m.in_data  = (idx < 10) ? bb[idx] : 8'h00;
        hs_in  = bus_m.in_valid && bus_m.in_ready;
        hs_out = bus_m.out_valid && bus_m.out_ready;
        got    = bus_m.out_sum;
        @(posedge clk);
        @(negedge clk);
        if (hs_in) idx++;
        if (hs_out) begin
          check("b2b_sum", got, (int'(bb[2*nres]) + int'(bb[2*nres+1])) % 256);
          check("b2b_count_w2", cnt_n, exp_seq[nres]);
          if (last_cyc >= 0) check("b2b_spacing", cyc - last_cyc, 5);
          last_cyc = cyc;
          nres++;
        end
      end
      check("b2b_results", nres, 5);
      bus_m.in_valid  = 1'b0;
      bus_m.out_ready = 1'b0;
      exp_count = 5;
    end

    // in_valid stays high with changing data through ISSUE/HOLD: nothing extra consumed
    send_byte(8'h3C, 1'b1);
    send_byte(8'h5A, 1'b1);
    finish_pair(8'h3C, 8'h5A, 8'h96, 4, 1'b1, 8'h21);
    send_byte(8'h21, 1'b1);
    send_byte(8'h03, 1'b0);
    finish_pair(8'h21, 8'h03, 8'h24, 0, 1'b0, 8'h00);

    // Randomized pairs against arithmetic reference
    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      int gap;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        @(negedge clk);
      end
      send_byte(ra, ($urandom_range(0, 1) == 1));
      send_byte(rb, 1'b0);
      finish_pair(ra, rb, 8'((int'(ra) + int'(rb)) % 256), $urandom_range(0, 3), 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
